// File: rtl/subblock_collector_pkg.sv
//------------------------------------------------------------------------------
// Module   : subblock_collector_pkg
// Purpose  : Shared lengths, FSM state encoding and meta-field constants for
//            the sub-block collector.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package subblock_collector_pkg;

  // Bytes per sub-block stream for the 1056-bit and 6144-bit block sizes
  localparam int LEN_SMALL_DEF = 132;
  localparam int LEN_LARGE_DEF = 768;

  // enc_meta bit that selects the large block length
  localparam int META_LEN_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD0   = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Counter width that holds a full three-stream large block without wrapping
  function automatic int cnt_width(input int len_large);
    return $clog2(3 * len_large + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/subblock_collector_if.sv
//------------------------------------------------------------------------------
// Module   : subblock_collector_if
// Purpose  : Serialized byte stream with valid/ready handshake, packet
//            delimiters and per-block metadata.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface subblock_collector_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic [7:0] out_meta;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_meta,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_meta,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/subblock_collector_out_skid_buf.sv
//------------------------------------------------------------------------------
// Module   : out_skid_buf
// Purpose  : Two-entry fall-through output buffer. An incoming word is
//            presented directly when the buffer is empty, so a returned byte
//            can be transferred in the same cycle it arrives.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         xfer,
  output logic [1:0]   occupancy
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic [1:0]   r_occ;
  logic         w_have;
  logic         w_pop;
  logic         w_push;

  assign w_have    = (r_occ != 2'd0);
  assign out_valid = w_have || in_valid;
  assign out_data  = w_have ? r_ent0 : (in_valid ? in_data : '0);
  assign xfer      = out_valid && out_ready;
  // A stored head leaves on transfer; the incoming word is kept unless it
  // bypassed straight to the output.
  assign w_pop     = xfer && w_have;
  assign w_push    = in_valid && !(xfer && !w_have);
  assign occupancy = r_occ;

  // Entry storage and occupancy; entry 0 is always the oldest word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ  <= 2'd0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      case ({w_pop, w_push})
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_ent0 <= in_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= in_data;
          end
        end
        2'b10: begin
          r_ent0 <= r_ent1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd0) r_ent0 <= in_data;
          else               r_ent1 <= in_data;
          r_occ <= r_occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/subblock_collector.sv
//------------------------------------------------------------------------------
// Module   : subblock_collector
// Purpose  : Reads the three sub-block streams of an encoded block in order
//            (q0, q1, q2) and serializes them onto a valid/ready byte stream
//            with sop/eop framing and latched block metadata.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module subblock_collector
  import subblock_collector_pkg::*;
#(
  parameter int LEN_SMALL = LEN_SMALL_DEF,
  parameter int LEN_LARGE = LEN_LARGE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_done,
  input  logic [7:0]           enc_meta,
  input  logic [7:0]           q0,
  input  logic [7:0]           q1,
  input  logic [7:0]           q2,
  output logic [2:0]           rdreq_subblock,
  output logic                 busy,
  output logic                 err_overrun,
  subblock_collector_if.master out
);

  localparam int CNT_W = cnt_width(LEN_LARGE);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [7:0]       r_meta;
  logic             r_err;
  // Tags of the read issued last cycle; its byte appears on q this cycle
  logic             r_inf_valid;
  logic [1:0]       r_inf_sel;
  logic             r_inf_sop;
  logic             r_inf_eop;

  logic             w_rd_state;
  logic [1:0]       w_idx;
  logic [1:0]       w_occ;
  logic             w_xfer;
  logic [2:0]       w_pend;
  logic             w_credit;
  logic             w_issue;
  logic             w_last;
  logic [7:0]       w_q_sel;
  logic [9:0]       w_in_data;
  logic             w_buf_valid;
  logic [9:0]       w_buf_data;

  // Which stream the current read state targets
  always_comb begin
    w_rd_state = 1'b1;
    w_idx      = 2'd0;
    case (r_state)
      ST_RD0:  w_idx = 2'd0;
      ST_RD1:  w_idx = 2'd1;
      ST_RD2:  w_idx = 2'd2;
      default: w_rd_state = 1'b0;
    endcase
  end

  // Credit: bytes held plus bytes returning, less the one leaving now, must
  // leave a free slot for the read about to be issued.
  assign w_pend   = {1'b0, w_occ} + {2'b00, r_inf_valid};
  assign w_credit = w_pend < (3'd2 + {2'b00, w_xfer});
  assign w_issue  = w_rd_state && w_credit;
  assign w_last   = (r_cnt == (r_len - CNT_W'(1)));

  assign rdreq_subblock = w_issue ? (3'b001 << w_idx) : 3'b000;

  // Route the stream that answered last cycle's read into the buffer
  always_comb begin
    w_q_sel = q2;
    case (r_inf_sel)
      2'd0:    w_q_sel = q0;
      2'd1:    w_q_sel = q1;
      default: w_q_sel = q2;
    endcase
  end

  assign w_in_data = {r_inf_sop, r_inf_eop, w_q_sel};

  out_skid_buf #(.W(10)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (r_inf_valid),
    .in_data   (w_in_data),
    .out_valid (w_buf_valid),
    .out_data  (w_buf_data),
    .out_ready (out.out_ready),
    .xfer      (w_xfer),
    .occupancy (w_occ)
  );

  assign out.out_valid = w_buf_valid;
  assign out.out_sop   = w_buf_data[9];
  assign out.out_eop   = w_buf_data[8];
  assign out.out_data  = w_buf_data[7:0];
  assign out.out_meta  = r_meta;
  assign busy          = (r_state != ST_IDLE);
  assign err_overrun   = r_err;

  // Block sequencing, read counting, metadata latch and overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_meta      <= 8'h00;
      r_err       <= 1'b0;
      r_inf_valid <= 1'b0;
      r_inf_sel   <= 2'd0;
      r_inf_sop   <= 1'b0;
      r_inf_eop   <= 1'b0;
    end else begin
      r_inf_valid <= w_issue;
      r_inf_sel   <= w_idx;
      r_inf_sop   <= w_issue && (r_state == ST_RD0) && (r_cnt == '0);
      r_inf_eop   <= w_issue && (r_state == ST_RD2) && w_last;

      // A new block cannot be taken while one is still in flight
      if (enc_done && (r_state != ST_IDLE)) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (enc_done) begin
            r_meta  <= enc_meta;
            r_len   <= enc_meta[META_LEN_BIT] ? CNT_W'(LEN_LARGE) : CNT_W'(LEN_SMALL);
            r_cnt   <= '0;
            r_state <= ST_RD0;
          end
        end
        ST_RD0, ST_RD1, ST_RD2: begin
          if (w_issue) begin
            if (w_last) begin
              r_cnt <= '0;
              case (r_state)
                ST_RD0:  r_state <= ST_RD1;
                ST_RD1:  r_state <= ST_RD2;
                default: r_state <= ST_DRAIN;
              endcase
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_xfer && w_buf_data[8]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
